// File: rtl/burst_bram_controller.sv
// Burst BRAM controller: runs one write or read burst per i_run pulse against a
// single-port BRAM. The address wraps modulo MEM_SIZE.
//
// Optional feature: define BRAM_RD_OUT_REG_EN to register o_read_data and
// o_read_valid. This adds one cycle of read latency and one S_DRAIN cycle.
//
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   i_run, i_mode             start pulse; mode 1 = write, 0 = read
//   i_base_addr, i_len        burst base address and length in words
//   i_write_data/valid        write stream in; o_write_ready handshake
//   o_idle..o_done            one-hot FSM state decode
//   bramAddr/Ce/We/WriteData  BRAM command side; bramReadData return
//   o_read_valid/data         read stream out
module burst_bram_controller #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned MEM_SIZE   = 1024,
  parameter int unsigned LEN_WIDTH  = 11,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_run,
  input  logic                  i_mode,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [LEN_WIDTH-1:0]  i_len,
  input  logic [DATA_WIDTH-1:0] i_write_data,
  input  logic                  i_write_valid,
  output logic                  o_write_ready,
  output logic                  o_idle,
  output logic                  o_write,
  output logic                  o_read,
  output logic                  o_drain,
  output logic                  o_done,
  output logic [ADDR_WIDTH-1:0] bramAddr,
  output logic                  bramCe,
  output logic                  bramWe,
  output logic [DATA_WIDTH-1:0] bramWriteData,
  input  logic [DATA_WIDTH-1:0] bramReadData,
  output logic                  o_read_valid,
  output logic [DATA_WIDTH-1:0] o_read_data
);

`ifdef BRAM_RD_OUT_REG_EN
  localparam int unsigned DrainCycles = RD_LATENCY + 1;
`else
  localparam int unsigned DrainCycles = RD_LATENCY;
`endif
  localparam logic [2:0]            DrainLast = 3'(DrainCycles - 1);
  localparam logic [ADDR_WIDTH-1:0] LastAddr  = ADDR_WIDTH'(MEM_SIZE - 1);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_e;

  state_e                  state_q, state_d;
  logic [LEN_WIDTH-1:0]    cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0]    len_q, len_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [2:0]              drain_q, drain_d;
  logic [RD_LATENCY-1:0]   vld_q, vld_d;
  logic [ADDR_WIDTH-1:0]   addr_inc;
  logic                    last_beat;
  logic                    issue;

  // The address is tracked incrementally as (base + cnt) mod MEM_SIZE.
  assign addr_inc  = (addr_q == LastAddr) ? '0 : addr_q + ADDR_WIDTH'(1);
  assign last_beat = ((cnt_q + LEN_WIDTH'(1)) == len_q);
  assign issue     = (state_q == S_READ);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    len_d         = len_q;
    addr_d        = addr_q;
    drain_d       = drain_q;
    bramCe        = 1'b0;
    bramWe        = 1'b0;
    o_write_ready = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (i_run) begin
          len_d  = i_len;
          cnt_d  = '0;
          addr_d = ADDR_WIDTH'(i_base_addr % MEM_SIZE);
          if (i_len == '0) state_d = S_DONE;
          else             state_d = i_mode ? S_WRITE : S_READ;
        end
      end
      S_WRITE: begin
        o_write_ready = 1'b1;
        if (i_write_valid) begin
          bramCe = 1'b1;
          bramWe = 1'b1;
          cnt_d  = cnt_q + LEN_WIDTH'(1);
          addr_d = addr_inc;
          if (last_beat) state_d = S_DONE;
        end
      end
      S_READ: begin
        bramCe = 1'b1;
        cnt_d  = cnt_q + LEN_WIDTH'(1);
        addr_d = addr_inc;
        if (last_beat) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end
      end
      S_DRAIN: begin
        drain_d = drain_q + 3'd1;
        if (drain_q == DrainLast) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Read-issue shift register; the top bit marks data returning from the BRAM.
  assign vld_d = RD_LATENCY'({vld_q, issue});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      addr_q  <= '0;
      drain_q <= '0;
      vld_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      drain_q <= drain_d;
      vld_q   <= vld_d;
    end
  end

`ifdef BRAM_RD_OUT_REG_EN
  logic                  rd_valid_q;
  logic [DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= vld_q[RD_LATENCY-1];
      if (vld_q[RD_LATENCY-1]) rd_data_q <= bramReadData;
    end
  end

  assign o_read_valid = rd_valid_q;
  assign o_read_data  = rd_data_q;
`else
  assign o_read_valid = vld_q[RD_LATENCY-1];
  assign o_read_data  = bramReadData;
`endif

  assign bramAddr      = addr_q;
  assign bramWriteData = i_write_data;
  assign o_idle        = (state_q == S_IDLE);
  assign o_write       = (state_q == S_WRITE);
  assign o_read        = (state_q == S_READ);
  assign o_drain       = (state_q == S_DRAIN);
  assign o_done        = (state_q == S_DONE);

endmodule

// File: tb/tb_burst_bram_controller.sv
// Self-checking bench for burst_bram_controller with a pipelined BRAM model.
// Expected writes, read addresses and read data are queued when stimulus is
// driven. A negedge monitor pops and compares them as the DUT produces them.
module tb_burst_bram_controller;

`ifdef BRAM_RD_OUT_REG_EN
  localparam int RD_LAT = 1;
  localparam int TL     = 2;
`else
  localparam int RD_LAT = 2;
  localparam int TL     = 2;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_run = 1'b0;
  logic        i_mode = 1'b0;
  logic [9:0]  i_base_addr = '0;
  logic [10:0] i_len = '0;
  logic [31:0] i_write_data = '0;
  logic        i_write_valid = 1'b0;
  logic        o_write_ready, o_idle, o_write, o_read, o_drain, o_done;
  logic [9:0]  bramAddr;
  logic        bramCe, bramWe;
  logic [31:0] bramWriteData, bramReadData;
  logic        o_read_valid;
  logic [31:0] o_read_data;
  logic [4:0]  st;

  assign st = {o_idle, o_write, o_read, o_drain, o_done};

  burst_bram_controller #(
    .DATA_WIDTH(32), .ADDR_WIDTH(10), .MEM_SIZE(1024), .LEN_WIDTH(11), .RD_LATENCY(RD_LAT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .i_run(i_run), .i_mode(i_mode),
    .i_base_addr(i_base_addr), .i_len(i_len), .i_write_data(i_write_data),
    .i_write_valid(i_write_valid), .o_write_ready(o_write_ready), .o_idle(o_idle),
    .o_write(o_write), .o_read(o_read), .o_drain(o_drain), .o_done(o_done),
    .bramAddr(bramAddr), .bramCe(bramCe), .bramWe(bramWe), .bramWriteData(bramWriteData),
    .bramReadData(bramReadData), .o_read_valid(o_read_valid), .o_read_data(o_read_data)
  );

  always #5 clk = ~clk;

  // BRAM model: RD_LAT-stage pipelined read.
  logic [31:0] mem [1024];
  logic [31:0] pipe [RD_LAT];
  always @(posedge clk) begin
    if (bramCe && bramWe) mem[bramAddr] <= bramWriteData;
    if (bramCe && !bramWe) pipe[0] <= mem[bramAddr];
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bramReadData = pipe[RD_LAT-1];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard queues and reference memory.
  int          wq_a[$];
  logic [31:0] wq_d[$];
  int          raq[$];
  logic [31:0] rq[$];
  logic [31:0] ref_mem [1024];
  int cyc = 0, ce_cnt = 0, we_cnt = 0, wcyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset_n) begin
      if (bramCe) ce_cnt <= ce_cnt + 1;
      if (o_write) wcyc <= wcyc + 1;
      if (bramCe && bramWe) begin
        we_cnt <= we_cnt + 1;
        check("we_pending", 64'(wq_a.size() != 0), 1);
        if (wq_a.size() != 0) begin
          check("wr_addr", bramAddr, 64'(wq_a.pop_front()));
          check("wr_data", bramWriteData, wq_d.pop_front());
        end
      end
      if (bramCe && !bramWe) begin
        check("rd_issue_pending", 64'(raq.size() != 0), 1);
        if (raq.size() != 0) check("rd_addr", bramAddr, 64'(raq.pop_front()));
      end
      if (o_read_valid) begin
        check("rv_pending", 64'(rq.size() != 0), 1);
        if (rq.size() != 0) check("rd_data", o_read_data, rq.pop_front());
      end
    end
  end

  task automatic start(input logic mode, input int base, input int len);
    i_run = 1'b1;
    i_mode = mode;
    i_base_addr = base[9:0];
    i_len = len[10:0];
    @(posedge clk); #1;
    i_run = 1'b0;
  endtask

  task automatic do_write(input int base, input int len, input logic [31:0] d0, input int gap);
    int we0, wc0, a;
    we0 = we_cnt;
    wc0 = wcyc;
    start(1'b1, base, len);
    for (int i = 0; i < len; i++) begin
      if (i == 1) begin
        repeat (gap) begin
          i_write_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      a = (base + i) % 1024;
      i_write_valid = 1'b1;
      i_write_data = d0 + 32'(i);
      wq_a.push_back(a);
      wq_d.push_back(d0 + 32'(i));
      ref_mem[a] = d0 + 32'(i);
      @(negedge clk);
      check("wr_ready", o_write_ready, 1);
      @(posedge clk); #1;
    end
    i_write_valid = 1'b0;
    @(negedge clk);
    check("wr_done_state", st, 5'b00001);
    @(posedge clk); #1;
    @(negedge clk);
    check("wr_idle_state", st, 5'b10000);
    check("wr_count", 64'(we_cnt - we0), 64'(len));
    check("wr_cycles", 64'(wcyc - wc0), 64'(len + gap));
    check("wr_queue_empty", 64'(wq_a.size()), 0);
    @(posedge clk); #1;
  endtask

  task automatic do_read(input int base, input int len);
    int c0, first, last, nv, nd;
    logic done;
    first = -1; last = -1; nv = 0; nd = 0; done = 1'b0;
    for (int i = 0; i < len; i++) begin
      raq.push_back((base + i) % 1024);
      rq.push_back(ref_mem[(base + i) % 1024]);
    end
    start(1'b0, base, len);
    c0 = cyc;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (k == 0) check("rd_state", st, 5'b00100);
      if (o_read_valid) begin
        if (first < 0) first = cyc;
        last = cyc;
        nv++;
      end
      if (o_drain) nd++;
      if (o_done) begin
        done = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check("rd_reached_done", done, 1);
    check("rd_first_latency", 64'(first - c0), 64'(TL));
    check("rd_beats", 64'(nv), 64'(len));
    check("rd_consecutive", 64'(last - first + 1), 64'(len));
    check("rd_drain_cycles", 64'(nd), 64'(TL));
    check("rd_queue_empty", 64'(rq.size()), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rd_idle_state", st, 5'b10000);
    @(posedge clk); #1;
  endtask

  initial begin
    int ce0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
    reset_n = 1'b0;
    #3;
    check("rst_state", st, 5'b10000);
    check("rst_ce", bramCe, 0);
    check("rst_we", bramWe, 0);
    check("rst_ready", o_write_ready, 0);
    check("rst_rvalid", o_read_valid, 0);
    // Initialise memory contents through the DUT so the model is fully defined.
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    do_write(32'h010, 4, 32'hA0, 0);
    do_write(32'h020, 3, 32'hB0, 2);
    do_read(32'h010, 4);
    do_write(32'h3FE, 4, 32'hC0, 0);
    do_read(32'h3FE, 4);
    do_read(32'h020, 3);

    // Zero-length burst, with i_run held through S_DONE.
    ce0 = ce_cnt;
    i_run = 1'b1; i_mode = 1'b0; i_base_addr = 10'h055; i_len = '0;
    @(posedge clk); #1;
    @(negedge clk);
    check("len0_done", st, 5'b00001);
    @(posedge clk); #1;
    i_run = 1'b0;
    @(negedge clk);
    check("len0_idle", st, 5'b10000);
    check("len0_no_ce", 64'(ce_cnt - ce0), 0);
    @(posedge clk); #1;

    // Reset asserted during the second issue of a len=8 read.
    for (int i = 0; i < 8; i++) begin
      raq.push_back(32'h010 + i);
      rq.push_back(ref_mem[32'h010 + i]);
    end
    start(1'b0, 32'h010, 8);
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    check("abort_idle", st, 5'b10000);
    check("abort_ce", bramCe, 0);
    raq.delete();
    rq.delete();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("abort_no_activity", 64'(raq.size() + rq.size()), 0);
    do_read(32'h011, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/burst_bram_controller.md
BURST_BRAM_CONTROLLER -- requirements
Module: burst_bram_controller

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning the BRAM word width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 10, meaning the BRAM address width.
REQ-003 The block SHALL have parameter MEM_SIZE, default 1024, meaning the number of BRAM words; MEM_SIZE <= 2^ADDR_WIDTH.
REQ-004 The block SHALL have parameter LEN_WIDTH, default 11, meaning the burst-length width.
REQ-005 The block SHALL have parameter RD_LATENCY, default 1, range 1..4, meaning the BRAM read latency in cycles.
REQ-006 The block SHALL have port clk, in, 1, the only clock; all logic is on its rising edge.
REQ-007 The block SHALL have port reset_n, in, 1, an asynchronous active-low reset.
REQ-008 The block SHALL have these control ports: i_run in 1 (start pulse); i_mode in 1 (1=write, 0=read); i_base_addr in ADDR_WIDTH; i_len in LEN_WIDTH (words in the burst).
REQ-009 The block SHALL have these write-stream ports: i_write_data in DATA_WIDTH; i_write_valid in 1; o_write_ready out 1.
REQ-010 The block SHALL have these status ports, each out 1: o_idle, o_write, o_read, o_drain, o_done.
REQ-011 The block SHALL have these BRAM ports: bramAddr out ADDR_WIDTH; bramCe out 1; bramWe out 1; bramWriteData out DATA_WIDTH; bramReadData in DATA_WIDTH.
REQ-012 The block SHALL have these read-stream ports: o_read_valid out 1; o_read_data out DATA_WIDTH.

Function
REQ-013 The FSM SHALL have states S_IDLE, S_WRITE, S_READ, S_DRAIN and S_DONE; o_idle, o_write, o_read, o_drain and o_done are the one-hot decodes of these states.
REQ-014 In S_IDLE, i_run=1 SHALL latch i_base_addr, i_len and i_mode, clear the word counter cnt, and move to S_WRITE (mode 1) or S_READ (mode 0); i_run is ignored in every other state.
REQ-015 A start with i_len=0 SHALL go directly from S_IDLE to S_DONE with no BRAM access.
REQ-016 The access address SHALL be (base+cnt) mod MEM_SIZE, so a burst that crosses MEM_SIZE-1 wraps to address 0.
REQ-017 In S_WRITE: o_write_ready=1; a beat is accepted when i_write_valid=1; on acceptance, bramCe=bramWe=1, bramWriteData=i_write_data and cnt increments.
REQ-018 In S_WRITE, when i_write_valid=0 the block SHALL stall with bramCe=0 and cnt held.
REQ-019 In S_WRITE, acceptance of beat len-1 SHALL move the FSM to S_DONE on the next edge.
REQ-020 In S_READ: bramCe=1, bramWe=0 and cnt increments every cycle with no stalls; after the issue at cnt=len-1 the FSM moves to S_DRAIN.
REQ-021 S_DRAIN SHALL last exactly RD_LATENCY cycles and then move to S_DONE; no BRAM access occurs in S_DRAIN.
REQ-022 A read-issue shift register of depth RD_LATENCY SHALL assert o_read_valid exactly RD_LATENCY cycles after each read issue, with o_read_data equal to the returned bramReadData; exactly len valid beats occur per read burst.
REQ-023 S_DONE SHALL last one cycle and then return to S_IDLE; i_run held high in S_DONE is ignored, so a new burst starts no earlier than the next cycle.
REQ-024 Outside S_WRITE and S_READ: bramCe=0, bramWe=0 and o_write_ready=0; bramAddr SHALL still show the current address.
REQ-025 cnt SHALL be LEN_WIDTH bits wide; i_len greater than MEM_SIZE is legal and rewrites or rereads wrapped addresses.

Reset
REQ-026 While reset_n=0, the FSM SHALL be in S_IDLE, cnt=0, the valid pipeline cleared, and o_read_valid, bramCe, bramWe and o_write_ready equal to 0.
REQ-027 Reset asserted mid-burst SHALL abort the burst immediately (asynchronously); no further BRAM access or o_read_valid occurs for the aborted burst.

Configuration
REQ-028 With BRAM_RD_OUT_REG_EN defined, o_read_data and o_read_valid SHALL be registered, so total read latency is RD_LATENCY+1, S_DRAIN lasts RD_LATENCY+1 cycles, and the data register resets to 0.
REQ-029 Without BRAM_RD_OUT_REG_EN, o_read_data SHALL equal bramReadData combinationally, and o_read_valid SHALL follow the RD_LATENCY pipeline only.

Verification
REQ-030 Write burst: base=0x010, len=4, i_write_valid held 1, data 0xA0..0xA3 -> 4 consecutive cycles with bramWe=1 at addresses 0x010..0x013, then S_DONE, then S_IDLE.
REQ-031 Write stall: len=3 with i_write_valid low for 2 cycles after beat 0 -> the burst spans 5 write cycles, exactly 3 writes, correct addresses, no extra bramWe.
REQ-032 Read back with RD_LATENCY=2 and macro off: base=0x010, len=4 -> o_read_valid high for 4 consecutive cycles starting 2 cycles after the first issue, data 0xA0..0xA3, then S_DONE.
REQ-033 Wrap: base=0x3FE, len=4, MEM_SIZE=1024 -> addresses 0x3FE, 0x3FF, 0x000, 0x001; len=0 -> S_IDLE, S_DONE, S_IDLE with bramCe never asserted.
REQ-034 Reset mid-read: reset_n pulsed low during the 2nd issue of a len=8 burst -> o_idle=1 immediately and no o_read_valid afterwards; a following len=1 read completes normally.
REQ-035 Macro on, RD_LATENCY=1: len=2 read -> first o_read_valid 2 cycles after the first issue, and S_DRAIN lasts 2 cycles.
